// File: rtl/display_pkg.sv
// Shared constants and types for the VGA overlay digit path.
package display_pkg;

  // Digit code the 7-segment renderer draws as background (digit off).
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Visible area of the 640x480 timing; vertical blanking starts at line 480.
  localparam int H_ACTIVE        = 640;
  localparam int V_ACTIVE        = 480;
  localparam int VBLANK_LINE_DEF = V_ACTIVE;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONV    = 3'd1,
    ST_FMT     = 3'd2,
    ST_WAIT_VB = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-add-3), one input bit per clock.
// A start pulse loads the operand; BIN_W shift steps follow. done is high
// during the cycle of the final shift, so bcd holds the result from the
// next cycle onward and keeps it until the next start.
module bin2bcd_serial
  import display_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int BCD_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int NNIB  = BCD_W / 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] adj;

  // Add-3 correction applied to every nibble of the accumulator.
  always_comb begin
    adj = '0;
    for (int i = 0; i < NNIB; i++) begin
      adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  // Load on start, otherwise shift {bcd, shreg} left while bits remain.
  always_comb begin
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    if (start) begin
      shreg_d = bin;
      bcd_d   = '0;
      cnt_d   = CNT_W'(BIN_W);
    end else if (cnt_q != '0) begin
      bcd_d   = {adj[BCD_W-2:0], shreg_q[BIN_W-1]};
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // Converter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_digit_ctrl.sv
// Score digit controller: converts a binary score to BCD, saturates and
// blanks leading zeros, then commits the digit codes at the start of
// vertical blanking so one frame never shows a half-updated number.
//
// Handshake: load is a single-cycle strobe with no ready; it is always
// accepted. While busy, a load lands in a one-deep pending slot (last
// wins) and is converted after the current commit. commit pulses for the
// one cycle in which digit_vals takes the new value at its closing edge.
module score_digit_ctrl
  import display_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int BIN_W       = 14,
  parameter int LZB         = 1,
  parameter int VBLANK_LINE = VBLANK_LINE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           hc,
  input  logic [9:0]           vc,
  input  logic                 load,
  input  logic [BIN_W-1:0]     bin_val,
  output logic                 busy,
  output logic [4*NDIGITS-1:0] digit_vals,
  output logic                 commit,
  output state_t               dbg_state
);

  localparam int                   DV_W    = 4 * NDIGITS;
  localparam int                   BCD_W   = 4 * (NDIGITS + 1);
  localparam longint unsigned      MAX_VAL = longint'(10 ** NDIGITS) - 1;
  localparam logic [DV_W-1:0]      ALL_9S  = {NDIGITS{4'h9}};

  // Power-up digit pattern: a single "0" (blanked above) or all zeros.
  function automatic logic [DV_W-1:0] reset_digits();
    logic [DV_W-1:0] r;
    r = '0;
    for (int i = 1; i < NDIGITS; i++) begin
      r[4*i +: 4] = (LZB != 0) ? DIGIT_BLANK : 4'h0;
    end
    return r;
  endfunction

  localparam logic [DV_W-1:0] RST_DIGITS = reset_digits();

  state_t             state_q, state_d;
  logic               pend_q, pend_d;
  logic [BIN_W-1:0]   pend_val_q, pend_val_d;
  logic [BIN_W-1:0]   cur_q, cur_d;
  logic [DV_W-1:0]    stage_q, stage_d;
  logic [DV_W-1:0]    dv_q, dv_d;

  logic               conv_start;
  logic [BIN_W-1:0]   conv_bin;
  logic               conv_done;
  logic [BCD_W-1:0]   bcd;

  logic               win;
  logic               sat;
  logic               lead;
  logic [DV_W-1:0]    fmt_val;

  bin2bcd_serial #(
    .BIN_W (BIN_W),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // The commit window is exactly one pixel clock: first pixel of the blanking line.
  assign win = (hc == 10'd0) && (vc == 10'(VBLANK_LINE));

  // Saturate out-of-range values to all 9s, then blank leading zeros above digit0.
  always_comb begin
    sat  = (64'(cur_q) > MAX_VAL);
    if (bcd[4*NDIGITS +: 4] != 4'h0) begin
      sat = 1'b1;
    end
    fmt_val = sat ? ALL_9S : bcd[DV_W-1:0];
    lead    = 1'b1;
    if (LZB != 0) begin
      for (int i = NDIGITS - 1; i >= 1; i--) begin
        if (lead && (fmt_val[4*i +: 4] == 4'h0)) begin
          fmt_val[4*i +: 4] = DIGIT_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
  end

  // Sequencing FSM with the pending-load slot and the commit of staged digits.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    cur_d      = cur_q;
    stage_d    = stage_q;
    dv_d       = dv_q;
    conv_start = 1'b0;
    conv_bin   = bin_val;

    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          conv_start = 1'b1;
          conv_bin   = bin_val;
          cur_d      = bin_val;
          state_d    = ST_CONV;
        end
      end

      ST_CONV: begin
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = bin_val;
        end
        if (conv_done) begin
          state_d = ST_FMT;
        end
      end

      ST_FMT: begin
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = bin_val;
        end
        stage_d = fmt_val;
        state_d = ST_WAIT_VB;
      end

      ST_WAIT_VB: begin
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = bin_val;
        end
        if (win) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        dv_d = stage_q;
        // A load arriving now is newer than anything pending, so it wins.
        if (load || pend_q) begin
          conv_start = 1'b1;
          conv_bin   = load ? bin_val : pend_val_q;
          cur_d      = conv_bin;
          pend_d     = 1'b0;
          state_d    = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers; reset drops any conversion and pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      cur_q      <= '0;
      stage_q    <= RST_DIGITS;
      dv_q       <= RST_DIGITS;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      cur_q      <= cur_d;
      stage_q    <= stage_d;
      dv_q       <= dv_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign commit     = (state_q == ST_COMMIT);
  assign digit_vals = dv_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Bench for score_digit_ctrl: two instances (leading-zero blanking on/off)
// share one stimulus. A compressed raster (4 clocks per line, 525 lines)
// keeps frames short while vc still reaches the blanking line.
module tb_score_digit_ctrl;
  import display_pkg::*;

  localparam int BIN_W = 14;
  localparam int H_TOT = 4;
  localparam int V_TOT = 525;
  localparam int VB    = 480;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int LAT   = BIN_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [9:0]        hc = '0;
  logic [9:0]        vc = '0;
  logic [BIN_W-1:0]  bin_val = '0;
  logic              busy_a, busy_b, commit_a, commit_b;
  logic [15:0]       dv_a, dv_b;
  state_t            st_a, st_b;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // ---------------- clock / raster ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hc == 10'(H_TOT - 1)) begin
        hc = '0;
        vc = (vc == 10'(V_TOT - 1)) ? 10'd0 : vc + 10'd1;
      end else begin
        hc = hc + 10'd1;
      end
    end
  end

  score_digit_ctrl #(.NDIGITS(4), .BIN_W(BIN_W), .LZB(1), .VBLANK_LINE(VB)) u_dut_a (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .load(load), .bin_val(bin_val),
    .busy(busy_a), .digit_vals(dv_a), .commit(commit_a), .dbg_state(st_a)
  );

  score_digit_ctrl #(.NDIGITS(4), .BIN_W(BIN_W), .LZB(0), .VBLANK_LINE(VB)) u_dut_b (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .load(load), .bin_val(bin_val),
    .busy(busy_b), .digit_vals(dv_b), .commit(commit_b), .dbg_state(st_b)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Decimal rendering of a value, straight from the display rules.
  function automatic logic [15:0] fmt(input int unsigned v, input bit lzb);
    int unsigned p10[4];
    int unsigned x, d;
    logic [15:0] r;
    bit seen;
    p10[0] = 1; p10[1] = 10; p10[2] = 100; p10[3] = 1000;
    x = (v > 9999) ? 9999 : v;
    seen = 1'b0;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      d = (x / p10[i]) % 10;
      if (d != 0) seen = 1'b1;
      r[4*i +: 4] = (lzb && !seen && i != 0) ? 4'hF : 4'(d);
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  // One in-flight value with the earliest usable window time, one pending
  // value, and a flag for the commit cycle that follows a used window.
  int          cyc = 0;
  bit          m_act = 0, m_inc = 0, m_pend = 0;
  int unsigned m_val = 0, m_pval = 0;
  int          m_rdy = 0;
  logic [15:0] m_dv1 = 16'hFFF0, m_dv0 = 16'h0000;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_act = 0; m_inc = 0; m_pend = 0;
        m_dv1 = 16'hFFF0; m_dv0 = 16'h0000;
      end else if (m_inc) begin
        m_dv1 = fmt(m_val, 1'b1);
        m_dv0 = fmt(m_val, 1'b0);
        m_inc = 0;
        if (load) begin
          m_val = bin_val; m_rdy = cyc + LAT;
        end else if (m_pend) begin
          m_val = m_pval; m_rdy = cyc + LAT;
        end else begin
          m_act = 0;
        end
        m_pend = 0;
      end else if (m_act) begin
        if (cyc >= m_rdy && hc == 10'd0 && vc == 10'(VB)) m_inc = 1;
        if (load) begin
          m_pend = 1; m_pval = bin_val;
        end
      end else if (load) begin
        m_act = 1; m_val = bin_val; m_rdy = cyc + LAT;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mon_busy_a",   32'(busy_a),   32'(m_act));
        chk("mon_busy_b",   32'(busy_b),   32'(m_act));
        chk("mon_commit_a", 32'(commit_a), 32'(m_inc));
        chk("mon_commit_b", 32'(commit_b), 32'(m_inc));
        chk("mon_dv_a",     32'(dv_a),     32'(m_dv1));
        chk("mon_dv_b",     32'(dv_b),     32'(m_dv0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int unsigned v);
    load = 1'b1;
    bin_val = BIN_W'(v);
    tick();
    load = 1'b0;
  endtask

  task automatic wait_line(input int v);
    int n = 0;
    while (!(hc == 10'd0 && vc == 10'(v)) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("wait_line_bound", 32'(n < 2 * FRAME), 32'd1);
  endtask

  // Advances until the commit pulse is visible (bounded).
  task automatic wait_commit();
    int n = 0;
    while (commit_a !== 1'b1 && n < 2 * FRAME + 100) begin
      tick();
      n++;
    end
    chk("commit_seen", 32'(commit_a), 32'd1);
  endtask

  typedef struct {
    int unsigned val;
    logic [15:0] e1;
    logic [15:0] e0;
  } vec_t;

  vec_t vecs[12];

  // ---------------- test sequence ----------------
  initial begin
    int ncommit;

    vecs[0]  = '{7,     16'hFFF7, 16'h0007};
    vecs[1]  = '{0,     16'hFFF0, 16'h0000};
    vecs[2]  = '{12000, 16'h9999, 16'h9999};
    vecs[3]  = '{9999,  16'h9999, 16'h9999};
    vecs[4]  = '{10000, 16'h9999, 16'h9999};
    vecs[5]  = '{16383, 16'h9999, 16'h9999};
    vecs[6]  = '{100,   16'hF100, 16'h0100};
    vecs[7]  = '{1000,  16'h1000, 16'h1000};
    vecs[8]  = '{5,     16'hFFF5, 16'h0005};
    vecs[9]  = '{90,    16'hFF90, 16'h0090};
    vecs[10] = '{305,   16'hF305, 16'h0305};
    vecs[11] = '{1234,  16'h1234, 16'h1234};

    // Reset, then idle for two frames.
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_dv_a", 32'(dv_a), 32'h0000FFF0);
    chk("reset_dv_b", 32'(dv_b), 32'h00000000);
    chk("reset_busy", 32'(busy_a), 32'd0);
    ncommit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (commit_a) ncommit++;
    end
    chk("idle_no_commit", 32'(ncommit), 32'd0);
    chk("idle_dv_a", 32'(dv_a), 32'h0000FFF0);

    // 1234 loaded at line 100: busy next cycle, commit just after the window.
    wait_line(100);
    chk("busy_before_load", 32'(busy_a), 32'd0);
    do_load(1234);
    chk("busy_after_load", 32'(busy_a), 32'd1);
    wait_commit();
    chk("commit_line", 32'(vc), 32'(VB));
    chk("commit_hc", 32'(hc), 32'd1);
    chk("dv_before_update", 32'(dv_a), 32'h0000FFF0);
    tick();
    chk("dv_1234_a", 32'(dv_a), 32'h00001234);
    chk("dv_1234_b", 32'(dv_b), 32'h00001234);
    chk("busy_after_commit", 32'(busy_a), 32'd0);

    // Table of single values.
    for (int i = 0; i < 12; i++) begin
      do_load(vecs[i].val);
      wait_commit();
      tick();
      chk($sformatf("vec%0d_dv_a", i), 32'(dv_a), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_dv_b", i), 32'(dv_b), 32'(vecs[i].e0));
    end

    // Loads during conversion: 42 first, 55 overwritten by 56.
    wait_line(100);
    do_load(42);
    tick(); tick();
    do_load(55);
    tick();
    do_load(56);
    wait_commit();
    tick();
    chk("seq_first_dv", 32'(dv_a), 32'h0000FF42);
    chk("seq_still_busy", 32'(busy_a), 32'd1);
    wait_commit();
    tick();
    chk("seq_second_dv", 32'(dv_a), 32'h0000FF56);
    chk("seq_second_dv_b", 32'(dv_b), 32'h00000056);
    chk("seq_idle", 32'(busy_a), 32'd0);

    // Reset in the middle of a conversion with a pending value queued.
    wait_line(200);
    do_load(5678);
    tick(); tick();
    do_load(1111);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_dv_a", 32'(dv_a), 32'h0000FFF0);
    chk("rst_mid_dv_b", 32'(dv_b), 32'h00000000);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    ncommit = 0;
    for (int i = 0; i < FRAME + 100; i++) begin
      tick();
      if (commit_a) ncommit++;
    end
    chk("rst_no_commit", 32'(ncommit), 32'd0);
    chk("rst_dv_kept", 32'(dv_a), 32'h0000FFF0);

    // Random loads and occasional resets against the model.
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 5999) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0: do_load($urandom_range(0, 9));
          1: do_load($urandom_range(0, 9999));
          2: do_load($urandom_range(9990, 10010));
          default: do_load($urandom_range(0, 16383));
        endcase
      end else begin
        tick();
      end
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
